rename_map_table: RTL
=====================

Name:
rename_map_table

Overview:
Parametrised register rename map for the OoO front end, and the successor to the fixed 2-wide speculative map.
- Holds a speculative map (SMT) and a committed map (CMT) for ARCH_REGS architectural registers.
- Serves RENAME_W instructions per cycle, with in-group dependency bypass and old-mapping readout for free-list release.
- On flush, restores SMT from CMT with a multi-cycle walk at RESTORE_W entries per cycle.

Parameters:
ARCH_REGS, 32, number of architectural registers (power of two)
PHYS_W, 6, physical register tag width
RENAME_W, 2, instructions renamed per cycle
COMMIT_W, 2, commit ports updating CMT
RESTORE_W, 4, entries copied CMT->SMT per restore cycle; must divide ARCH_REGS
X0_FIXED, 1, arch reg 0 hard-mapped to phys 0

Ports:
cpu_clk_i  in  1  clock
cpu_rst_ni  in  1  synchronous active-low reset
ren_valid_i  in  1  rename group valid
rs1_i  in  RENAME_W*5  source 1 arch reg, per lane
rs2_i  in  RENAME_W*5  source 2 arch reg, per lane
rd_i  in  RENAME_W*5  destination arch reg, per lane
rd_we_i  in  RENAME_W  lane writes rd
new_phys_i  in  RENAME_W*PHYS_W  allocated phys tag, per lane
rs1_phys_o  out  RENAME_W*PHYS_W  renamed source 1
rs2_phys_o  out  RENAME_W*PHYS_W  renamed source 2
old_phys_o  out  RENAME_W*PHYS_W  prior mapping of rd, per lane
cmt_we_i  in  COMMIT_W  commit port valid
cmt_arch_i  in  COMMIT_W*5  committed arch reg
cmt_phys_i  in  COMMIT_W*PHYS_W  committed phys tag
flush_i  in  1  pipeline flush; start restore
busy_o  out  1  restore in progress; rename must stall

Behaviour:
- Clocking and reset: single clock cpu_clk_i; cpu_rst_ni is synchronous, active-low.
- Reset:
  - Every SMT and CMT entry i = i (identity).
  - FSM = IDLE, restore pointer = 0, busy_o = 0.
  - Reset dominates flush_i and all writes, including mid-restore.
- Reads (combinational, 0 cycles):
  - Lane j source = newest older-lane write (highest k<j, ren_valid_i & rd_we_i[k], rd_i[k] == src) if any, else SMT[src].
  - old_phys_o[j] uses the same rule with rd_i[j].
- X0_FIXED=1:
  - Reads of arch 0 return 0, including old_phys_o.
  - Writes to arch 0 are ignored in SMT, CMT and the bypass.
- SMT write:
  - Occurs at the clock edge when ren_valid_i & rd_we_i[j] & !busy_o & !flush_i; visible the next cycle.
  - Same rd in several lanes: the highest lane wins.
- CMT write:
  - Occurs on cmt_we_i[c], including in the flush cycle.
  - Same arch in several ports: the highest port wins.
- FSM states:
  - IDLE --flush_i--> RESTORE, ptr = 0.
  - RESTORE: each cycle SMT[ptr+k] <= CMT[ptr+k] for k < RESTORE_W; ptr += RESTORE_W. At ptr = ARCH_REGS - RESTORE_W the FSM returns to IDLE after that copy.
  - flush_i in RESTORE restarts the walk: ptr = 0, stay in RESTORE.
- busy_o = (state == RESTORE). Default config: high for exactly 8 cycles, starting the cycle after flush_i.
- Rename writes are dropped in the flush cycle and while busy_o is high. Read outputs remain driven but are don't-care.
- cmt_we_i asserted during RESTORE is illegal; a bench assertion flags it. The RTL applies it to CMT only.
- Width rule: ptr width is clog2(ARCH_REGS); no wrap beyond the last group.

Decomposition:
- Package rename_pkg: arch-reg index width (5), phys tag typedef sized by PHYS_W, restore FSM state enum (IDLE, RESTORE).
- Sub-module rmt_restore_ctrl: FSM, pointer, busy_o and restore-group index generation.
- Top-level module: tables and bypass network.

Test Plan:
- Reset, then read rs1 = 7, rs2 = 31 on lane 0 -> 7 and 31; busy_o = 0.
- Lane0 rd=5 new=40; lane1 rs1=5, rd=5 new=41 -> lane1 rs1_phys=40, old_phys=40. Next cycle, read x5 -> 41.
- CMT x3 -> 45 via commit; SMT x3 -> 50 via rename; pulse flush_i:
  - busy_o is high for 8 cycles and rename writes are ignored.
  - After the walk, read x3 -> 45 and x9 -> 9.
- flush_i again at restore cycle 5 -> walk restarts; busy_o stays high 8 more cycles (13 total); final contents equal CMT.
- Rename rd=0 new=33, then commit x0 -> 34 -> reads of x0 return 0; old_phys for rd=0 returns 0.
- Both commit ports write x12 (20 on port 0, 21 on port 1), then flush -> after restore, x12 reads 21.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared types for the rename map: arch-reg index, default phys tag and the
// restore walk state encoding.
package rename_pkg;

  localparam int AREG_W     = 5;
  localparam int PHYS_W_DEF = 6;

  typedef logic [AREG_W-1:0]     areg_t;
  typedef logic [PHYS_W_DEF-1:0] ptag_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RESTORE = 1'b1
  } restore_state_e;

endpackage

// File: rtl/rmt_restore_ctrl.sv
// Restore walk controller: steps a group pointer across the map, RESTORE_W
// entries per cycle, while busy_o holds rename off.
module rmt_restore_ctrl
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = 32,
  parameter int RESTORE_W = 4,
  parameter int PTR_W     = $clog2(ARCH_REGS)
) (
  input  logic             cpu_clk_i,
  input  logic             cpu_rst_ni,
  input  logic             flush_i,
  output logic             busy_o,
  output logic [PTR_W-1:0] ptr_o
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ARCH_REGS - RESTORE_W);
  localparam logic [PTR_W-1:0] STEP     = PTR_W'(RESTORE_W);

  restore_state_e   state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d = ST_RESTORE;
          ptr_d   = '0;
        end
      end
      ST_RESTORE: begin
        // A new flush restarts the walk from the first group.
        if (flush_i) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + STEP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge cpu_clk_i) begin
    if (!cpu_rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy_o = (state_q == ST_RESTORE);
  assign ptr_o  = ptr_q;

endmodule

// File: rtl/rename_map_table.sv
// Speculative and committed register rename maps with in-group bypass and
// a multi-cycle CMT->SMT restore after flush.
module rename_map_table
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_W    = 6,
  parameter int RENAME_W  = 2,
  parameter int COMMIT_W  = 2,
  parameter int RESTORE_W = 4,
  parameter int X0_FIXED  = 1
) (
  input  logic                         cpu_clk_i,
  input  logic                         cpu_rst_ni,
  input  logic                         ren_valid_i,
  input  logic [RENAME_W*AREG_W-1:0]   rs1_i,
  input  logic [RENAME_W*AREG_W-1:0]   rs2_i,
  input  logic [RENAME_W*AREG_W-1:0]   rd_i,
  input  logic [RENAME_W-1:0]          rd_we_i,
  input  logic [RENAME_W*PHYS_W-1:0]   new_phys_i,
  output logic [RENAME_W*PHYS_W-1:0]   rs1_phys_o,
  output logic [RENAME_W*PHYS_W-1:0]   rs2_phys_o,
  output logic [RENAME_W*PHYS_W-1:0]   old_phys_o,
  input  logic [COMMIT_W-1:0]          cmt_we_i,
  input  logic [COMMIT_W*AREG_W-1:0]   cmt_arch_i,
  input  logic [COMMIT_W*PHYS_W-1:0]   cmt_phys_i,
  input  logic                         flush_i,
  output logic                         busy_o
);

  localparam int PTR_W = $clog2(ARCH_REGS);

  logic [PHYS_W-1:0] smt_q [ARCH_REGS];
  logic [PHYS_W-1:0] smt_d [ARCH_REGS];
  logic [PHYS_W-1:0] cmt_q [ARCH_REGS];
  logic [PHYS_W-1:0] cmt_d [ARCH_REGS];
  logic [PTR_W-1:0]  ptr;
  logic              busy;

  rmt_restore_ctrl #(
    .ARCH_REGS (ARCH_REGS),
    .RESTORE_W (RESTORE_W),
    .PTR_W     (PTR_W)
  ) u_restore_ctrl (
    .cpu_clk_i  (cpu_clk_i),
    .cpu_rst_ni (cpu_rst_ni),
    .flush_i    (flush_i),
    .busy_o     (busy),
    .ptr_o      (ptr)
  );

  assign busy_o = busy;

  function automatic logic is_x0(areg_t a);
    return (X0_FIXED != 0) && (a == '0);
  endfunction

  // Newest older-lane write to the same arch reg wins over the SMT entry.
  function automatic logic [PHYS_W-1:0] map_read(int lane, areg_t a);
    logic [PHYS_W-1:0] v;
    v = smt_q[a];
    for (int k = 0; k < RENAME_W; k++) begin
      if ((k < lane) && ren_valid_i && rd_we_i[k] &&
          (rd_i[k*AREG_W +: AREG_W] == a) && !is_x0(a)) begin
        v = new_phys_i[k*PHYS_W +: PHYS_W];
      end
    end
    if (is_x0(a)) begin
      v = '0;
    end
    return v;
  endfunction

  always_comb begin
    rs1_phys_o = '0;
    rs2_phys_o = '0;
    old_phys_o = '0;
    for (int j = 0; j < RENAME_W; j++) begin
      rs1_phys_o[j*PHYS_W +: PHYS_W] = map_read(j, rs1_i[j*AREG_W +: AREG_W]);
      rs2_phys_o[j*PHYS_W +: PHYS_W] = map_read(j, rs2_i[j*AREG_W +: AREG_W]);
      old_phys_o[j*PHYS_W +: PHYS_W] = map_read(j, rd_i[j*AREG_W +: AREG_W]);
    end
  end

  // Restore and rename writes never coincide: rename is blocked while busy.
  always_comb begin
    logic [PTR_W-1:0] idx;
    areg_t            a;
    smt_d = smt_q;
    idx   = '0;
    a     = '0;
    if (busy) begin
      for (int k = 0; k < RESTORE_W; k++) begin
        idx        = ptr + PTR_W'(k);
        smt_d[idx] = cmt_q[idx];
      end
    end else if (ren_valid_i && !flush_i) begin
      for (int j = 0; j < RENAME_W; j++) begin
        a = rd_i[j*AREG_W +: AREG_W];
        if (rd_we_i[j] && !is_x0(a)) begin
          smt_d[a] = new_phys_i[j*PHYS_W +: PHYS_W];
        end
      end
    end
  end

  always_comb begin
    areg_t a;
    cmt_d = cmt_q;
    a     = '0;
    for (int c = 0; c < COMMIT_W; c++) begin
      a = cmt_arch_i[c*AREG_W +: AREG_W];
      if (cmt_we_i[c] && !is_x0(a)) begin
        cmt_d[a] = cmt_phys_i[c*PHYS_W +: PHYS_W];
      end
    end
  end

  always_ff @(posedge cpu_clk_i) begin
    if (!cpu_rst_ni) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        smt_q[i] <= PHYS_W'(i);
        cmt_q[i] <= PHYS_W'(i);
      end
    end else begin
      smt_q <= smt_d;
      cmt_q <= cmt_d;
    end
  end

endmodule
